gsram_dp_mask: RTL and testbench

GSRAM_DP_MASK -- requirements
Module: gsram_dp_mask

---
 rtl/gsram_dp_mask.sv | 106 ++++++++++
 tb/tb_gsram_dp_mask.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gsram_dp_mask.sv
// Dual-port bit-masked SRAM with optional zero-fill after reset; 1-cycle registered reads.
// Latency: Q valid one edge after CE sample; INIT_DONE rises 2**ABITS edges after reset release.
module gsram_dp_mask #(
  parameter int ABITS    = 14,
  parameter int DBITS    = 1,
  parameter int CLEAR_EN = 1
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [ABITS-1:0] A0,
  input  logic [DBITS-1:0] D0,
  input  logic [DBITS-1:0] WEM0,
  input  logic             WE0,
  input  logic             CE0,
  output logic [DBITS-1:0] Q0,
  input  logic [ABITS-1:0] A1,
  input  logic [DBITS-1:0] D1,
  input  logic [DBITS-1:0] WEM1,
  input  logic             WE1,
  input  logic             CE1,
  output logic [DBITS-1:0] Q1,
  output logic             INIT_DONE
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_q, state_d;
  logic [ABITS-1:0] cnt_q, cnt_d;
  logic [DBITS-1:0] q0_q, q1_q;
  logic             init_done_q;

  logic [DBITS-1:0] mem [2**ABITS];

  logic             ready;
  logic             wr0, wr1, same_addr;
  logic [DBITS-1:0] old0, old1, mrg1, base0, fin0, fin1;

  function automatic logic [DBITS-1:0] merge(input logic [DBITS-1:0] old_w,
                                             input logic [DBITS-1:0] dat,
                                             input logic [DBITS-1:0] msk);
    return (old_w & ~msk) | (dat & msk);
  endfunction

  // Counter exits on its all-ones value, so it never needs to wrap to detect completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + ABITS'(1);
        if (CLEAR_EN == 0 || cnt_q == {ABITS{1'b1}}) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  // Port 1 merges first and port 0 on top, so port 0 owns contested bits on a shared address.
  always_comb begin
    ready     = (state_q == READY);
    wr0       = ready && CE0 && WE0;
    wr1       = ready && CE1 && WE1;
    same_addr = (A0 == A1);
    old0      = mem[A0];
    old1      = mem[A1];
    mrg1      = wr1 ? merge(old1, D1, WEM1) : old1;
    base0     = (same_addr && wr1) ? mrg1 : old0;
    fin0      = wr0 ? merge(base0, D0, WEM0) : base0;
    fin1      = same_addr ? fin0 : mrg1;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= CLEAR;
      cnt_q       <= '0;
      q0_q        <= '0;
      q1_q        <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == READY);
      if (!ready) begin
        q0_q <= '0;
        q1_q <= '0;
      end else begin
        if (CE0) q0_q <= fin0;
        if (CE1) q1_q <= fin1;
      end
    end
  end

  // Array sits outside the reset domain; a reset only restarts the fill walk.
  always_ff @(posedge CLK) begin
    if (!ready) begin
      if (CLEAR_EN != 0) mem[cnt_q] <= '0;
    end else begin
      if (wr1) mem[A1] <= fin1;
      if (wr0) mem[A0] <= fin0;
    end
  end

  assign Q0        = q0_q;
  assign Q1        = q1_q;
  assign INIT_DONE = init_done_q;

endmodule

// File: tb/tb_gsram_dp_mask.sv
// Self-checking bench for gsram_dp_mask (ABITS=4, DBITS=8, CLEAR_EN=1) against an array model.
module tb_gsram_dp_mask;

  logic       CLK;
  logic       RSTN;
  logic [3:0] A0, A1;
  logic [7:0] D0, D1, WEM0, WEM1;
  logic       WE0, WE1, CE0, CE1;
  logic [7:0] Q0, Q1;
  logic       INIT_DONE;

  int checks = 0;
  int errors = 0;

  logic [7:0] ref_mem [16];
  logic [7:0] exp_q0, exp_q1;

  gsram_dp_mask #(.ABITS(4), .DBITS(8), .CLEAR_EN(1)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .A0(A0), .D0(D0), .WEM0(WEM0), .WE0(WE0), .CE0(CE0), .Q0(Q0),
    .A1(A1), .D1(D1), .WEM1(WEM1), .WE1(WE1), .CE1(CE1), .Q1(Q1),
    .INIT_DONE(INIT_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic idle_inputs();
    CE0 = 0; WE0 = 0; A0 = 0; D0 = 0; WEM0 = 0;
    CE1 = 0; WE1 = 0; A1 = 0; D1 = 0; WEM1 = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    exp_q0 = 8'h00;
    exp_q1 = 8'h00;
  endtask

  // One READY-state cycle on both ports; the model applies port 1 then port 0 so port 0 wins.
  task automatic do_cycle(input logic c0, input logic w0, input logic [3:0] a0,
                          input logic [7:0] d0, input logic [7:0] m0,
                          input logic c1, input logic w1, input logic [3:0] a1,
                          input logic [7:0] d1, input logic [7:0] m1);
    @(negedge CLK);
    CE0 = c0; WE0 = w0; A0 = a0; D0 = d0; WEM0 = m0;
    CE1 = c1; WE1 = w1; A1 = a1; D1 = d1; WEM1 = m1;
    @(posedge CLK);
    if (c1 && w1) ref_mem[a1] = (ref_mem[a1] & ~m1) | (d1 & m1);
    if (c0 && w0) ref_mem[a0] = (ref_mem[a0] & ~m0) | (d0 & m0);
    if (c0) exp_q0 = ref_mem[a0];
    if (c1) exp_q1 = ref_mem[a1];
    #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if (Q0 !== 8'h00 || Q1 !== 8'h00 || INIT_DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Q0=%h Q1=%h INIT_DONE=%b, want 00 00 0", Q0, Q1, INIT_DONE);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    checks++;
    if (INIT_DONE !== 1'b0) begin
      errors++;
      $display("FAIL init_done_at_release: got %b want 0", INIT_DONE);
    end
    for (int k = 1; k <= 17; k++) begin
      @(posedge CLK);
      #1;
      checks++;
      if (INIT_DONE !== (k >= 16)) begin
        errors++;
        $display("FAIL init_done_edge%0d: got %b want %b", k, INIT_DONE, (k >= 16));
      end
    end
  endtask

  task automatic test_clear_readback();
    for (int i = 0; i < 16; i++) begin
      do_cycle(1, 0, 4'(i), 8'h5A, 8'hFF, 1, 0, 4'(15 - i), 8'hA5, 8'hFF);
      checks++;
      if (Q0 !== 8'h00 || Q1 !== 8'h00) begin
        errors++;
        $display("FAIL clear_readback addr%0d: Q0=%h Q1=%h want 00 00", i, Q0, Q1);
      end
    end
  endtask

  task automatic test_write_through();
    do_cycle(1, 1, 4'd3, 8'hAB, 8'hFF, 0, 0, 4'd0, 8'h00, 8'h00);
    checks++;
    if (Q0 !== 8'hAB) begin
      errors++;
      $display("FAIL write_through_q0: got %h want ab", Q0);
    end
    do_cycle(0, 0, 4'd0, 8'h00, 8'h00, 1, 0, 4'd3, 8'h00, 8'h00);
    checks++;
    if (Q1 !== 8'hAB || Q0 !== 8'hAB) begin
      errors++;
      $display("FAIL read_after_write: Q1=%h Q0=%h want ab ab", Q1, Q0);
    end
  endtask

  task automatic test_ww_collision();
    do_cycle(1, 1, 4'd5, 8'hFF, 8'h0F, 1, 1, 4'd5, 8'hAA, 8'hFF);
    checks++;
    if (Q0 !== 8'hAF || Q1 !== 8'hAF) begin
      errors++;
      $display("FAIL ww_collision: Q0=%h Q1=%h want af af", Q0, Q1);
    end
    do_cycle(1, 0, 4'd5, 8'h00, 8'h00, 0, 0, 4'd0, 8'h00, 8'h00);
    checks++;
    if (Q0 !== 8'hAF) begin
      errors++;
      $display("FAIL ww_collision_stored: got %h want af", Q0);
    end
    do_cycle(1, 1, 4'd5, 8'h12, 8'h00, 0, 0, 4'd0, 8'h00, 8'h00);
    checks++;
    if (Q0 !== 8'hAF) begin
      errors++;
      $display("FAIL zero_mask_write: got %h want af", Q0);
    end
  endtask

  task automatic test_wr_bypass();
    do_cycle(0, 0, 4'd0, 8'h00, 8'h00, 1, 1, 4'd7, 8'h11, 8'hFF);
    do_cycle(1, 1, 4'd7, 8'h22, 8'hFF, 1, 0, 4'd7, 8'h00, 8'h00);
    checks++;
    if (Q1 !== 8'h22 || Q0 !== 8'h22) begin
      errors++;
      $display("FAIL wr_bypass: Q1=%h Q0=%h want 22 22", Q1, Q0);
    end
  endtask

  task automatic test_ce_hold();
    logic [7:0] h0, h1;
    do_cycle(1, 1, 4'd9, 8'h3C, 8'hFF, 1, 1, 4'd10, 8'hC3, 8'hFF);
    h0 = exp_q0;
    h1 = exp_q1;
    @(negedge CLK);
    CE0 = 0; WE0 = 1; A0 = 4'd9;  D0 = 8'hFF; WEM0 = 8'hFF;
    CE1 = 0; WE1 = 1; A1 = 4'd10; D1 = 8'h00; WEM1 = 8'hFF;
    @(posedge CLK);
    #1;
    idle_inputs();
    checks++;
    if (Q0 !== h0 || Q1 !== h1) begin
      errors++;
      $display("FAIL ce_hold_q: Q0=%h Q1=%h want %h %h", Q0, Q1, h0, h1);
    end
    do_cycle(1, 0, 4'd9, 8'h00, 8'h00, 1, 0, 4'd10, 8'h00, 8'h00);
    checks++;
    if (Q0 !== 8'h3C || Q1 !== 8'hC3) begin
      errors++;
      $display("FAIL ce_hold_mem: Q0=%h Q1=%h want 3c c3", Q0, Q1);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [7:0] m0, m1;
      m0 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      m1 = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      do_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 15)),
               8'($urandom), m0,
               1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 15)),
               8'($urandom), m1);
      checks++;
      if (Q0 !== exp_q0 || Q1 !== exp_q1) begin
        errors++;
        $display("FAIL random_cycle%0d: Q0=%h Q1=%h want %h %h", n, Q0, Q1, exp_q0, exp_q1);
      end
    end
  endtask

  task automatic drive_random_access();
    CE0 = 1; WE0 = 1'($urandom); A0 = 4'($urandom); D0 = 8'($urandom | 1); WEM0 = 8'hFF;
    CE1 = 1; WE1 = 1'($urandom); A1 = 4'($urandom); D1 = 8'($urandom | 1); WEM1 = 8'hFF;
  endtask

  task automatic test_reset_mid_clear();
    do_cycle(1, 1, 4'd2, 8'h77, 8'hFF, 1, 1, 4'd4, 8'h88, 8'hFF);
    #2;
    RSTN = 1'b0;
    #1;
    checks++;
    if (Q0 !== 8'h00 || Q1 !== 8'h00 || INIT_DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready: Q0=%h Q1=%h INIT_DONE=%b want 00 00 0", Q0, Q1, INIT_DONE);
    end
    model_reset();
    @(negedge CLK);
    RSTN = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      drive_random_access();
      @(posedge CLK);
      #1;
      checks++;
      if (Q0 !== 8'h00 || Q1 !== 8'h00 || INIT_DONE !== 1'b0) begin
        errors++;
        $display("FAIL clear_first_pass_edge%0d: Q0=%h Q1=%h INIT_DONE=%b", k, Q0, Q1, INIT_DONE);
      end
      @(negedge CLK);
    end
    #2;
    RSTN = 1'b0;
    #1;
    checks++;
    if (Q0 !== 8'h00 || Q1 !== 8'h00 || INIT_DONE !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_clear: Q0=%h Q1=%h INIT_DONE=%b", Q0, Q1, INIT_DONE);
    end
    @(negedge CLK);
    RSTN = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      if (k <= 16) drive_random_access();
      else idle_inputs();
      @(posedge CLK);
      #1;
      checks++;
      if (INIT_DONE !== (k >= 16) || Q0 !== 8'h00 || Q1 !== 8'h00) begin
        errors++;
        $display("FAIL refill_edge%0d: INIT_DONE=%b want %b Q0=%h Q1=%h want 00", k, INIT_DONE,
                 (k >= 16), Q0, Q1);
      end
      @(negedge CLK);
    end
    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      do_cycle(1, 0, 4'(i), 8'h00, 8'h00, 1, 0, 4'(15 - i), 8'h00, 8'h00);
      checks++;
      if (Q0 !== 8'h00 || Q1 !== 8'h00) begin
        errors++;
        $display("FAIL refill_readback addr%0d: Q0=%h Q1=%h want 00 00", i, Q0, Q1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_readback();
    test_write_through();
    test_ww_collision();
    test_wr_bypass();
    test_ce_hold();
    test_random();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
